// File: rtl/alu_cmd_issuer_if.sv
// Handshake bundle for the ALU command issuer: upstream command port,
// downstream response port and the ALU start/done operation interface.
interface alu_cmd_issuer_if #(
  parameter int TAG_W = 4
);
  // Upstream command port
  logic             cmd_valid;
  logic             cmd_ready;
  logic [7:0]       cmd_a;
  logic [7:0]       cmd_b;
  logic [2:0]       cmd_op;
  logic [TAG_W-1:0] cmd_tag;

  // Downstream response port
  logic             rsp_valid;
  logic             rsp_ready;
  logic [15:0]      rsp_result;
  logic [2:0]       rsp_op;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_timeout;

  // ALU operation interface
  logic [7:0]       alu_A;
  logic [7:0]       alu_B;
  logic [2:0]       alu_opcode;
  logic             alu_start;
  logic [15:0]      alu_result;
  logic             alu_done;

  // Issuer side
  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag,
    input  rsp_ready,
    input  alu_result, alu_done,
    output cmd_ready,
    output rsp_valid, rsp_result, rsp_op, rsp_tag, rsp_timeout,
    output alu_A, alu_B, alu_opcode, alu_start
  );

  // Environment side (command source, response sink, ALU)
  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag,
    output rsp_ready,
    output alu_result, alu_done,
    input  cmd_ready,
    input  rsp_valid, rsp_result, rsp_op, rsp_tag, rsp_timeout,
    input  alu_A, alu_B, alu_opcode, alu_start
  );
endinterface

// File: rtl/alu_cmd_issuer.sv
// ALU command issuer: accepts a command, pulses alu_start for one cycle,
// waits for alu_done (or a timeout) and returns a tagged response.
// All outputs come straight from flops.
module alu_cmd_issuer #(
  parameter int TAG_W          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  alu_cmd_issuer_if.master        bus,
  output logic                    busy,
  output logic [15:0]             op_count,
  output logic [7:0]              timeout_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // The counter starts at 0 in the first WAIT cycle, so the last allowed
  // WAIT cycle is the one where it reads TIMEOUT_CYCLES-1.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t           state_q;
  logic             cmd_ready_q;
  logic             rsp_valid_q;
  logic [15:0]      rsp_result_q;
  logic [2:0]       rsp_op_q;
  logic [TAG_W-1:0] rsp_tag_q;
  logic             rsp_timeout_q;
  logic [7:0]       alu_a_q;
  logic [7:0]       alu_b_q;
  logic [2:0]       alu_op_q;
  logic             alu_start_q;
  logic [TAG_W-1:0] tag_q;
  logic [7:0]       wait_cnt_q;
  logic             busy_q;
  logic [15:0]      op_count_q;
  logic [7:0]       timeout_count_q;

  // Issuer FSM with all datapath and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      cmd_ready_q     <= 1'b1;
      rsp_valid_q     <= 1'b0;
      rsp_result_q    <= 16'h0000;
      rsp_op_q        <= 3'b000;
      rsp_tag_q       <= '0;
      rsp_timeout_q   <= 1'b0;
      alu_a_q         <= 8'h00;
      alu_b_q         <= 8'h00;
      alu_op_q        <= 3'b000;
      alu_start_q     <= 1'b0;
      tag_q           <= '0;
      wait_cnt_q      <= 8'h00;
      busy_q          <= 1'b0;
      op_count_q      <= 16'h0000;
      timeout_count_q <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            alu_a_q     <= bus.cmd_a;
            alu_b_q     <= bus.cmd_b;
            alu_op_q    <= bus.cmd_op;
            tag_q       <= bus.cmd_tag;
            cmd_ready_q <= 1'b0;
            alu_start_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          // alu_done is deliberately not looked at here: anything the ALU
          // reports in the start cycle belongs to an older operation.
          alu_start_q <= 1'b0;
          wait_cnt_q  <= 8'h00;
          state_q     <= WAIT;
        end
        WAIT: begin
          if (bus.alu_done) begin
            // Done takes priority over a timeout falling in the same cycle.
            rsp_result_q  <= bus.alu_result;
            rsp_timeout_q <= 1'b0;
            rsp_op_q      <= alu_op_q;
            rsp_tag_q     <= tag_q;
            rsp_valid_q   <= 1'b1;
            state_q       <= RESP;
          end else if (wait_cnt_q == WAIT_LAST) begin
            rsp_result_q  <= 16'h0000;
            rsp_timeout_q <= 1'b1;
            rsp_op_q      <= alu_op_q;
            rsp_tag_q     <= tag_q;
            rsp_valid_q   <= 1'b1;
            if (timeout_count_q != 8'hFF) begin
              timeout_count_q <= timeout_count_q + 8'd1;
            end
            state_q       <= RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        RESP: begin
          // cmd_ready only rises after the handshake edge, so a new command
          // can never be accepted in the handshake cycle itself.
          if (bus.rsp_ready) begin
            op_count_q  <= op_count_q + 16'd1;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          alu_start_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_op      = rsp_op_q;
  assign bus.rsp_tag     = rsp_tag_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.alu_A       = alu_a_q;
  assign bus.alu_B       = alu_b_q;
  assign bus.alu_opcode  = alu_op_q;
  assign bus.alu_start   = alu_start_q;
  assign busy            = busy_q;
  assign op_count        = op_count_q;
  assign timeout_count   = timeout_count_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer: directed scenarios plus random
// commands, compared against a transaction-level expectation model.
module tb_alu_cmd_issuer;

  localparam int TO = 64;

  logic        clk;
  logic        rst;
  logic        busy;
  logic [15:0] op_count;
  logic [7:0]  timeout_count;

  int          checks;
  int          errors;
  logic [15:0] exp_ops;
  logic [7:0]  exp_tos;

  alu_cmd_issuer_if #(.TAG_W(4)) bus ();

  alu_cmd_issuer #(.TAG_W(4), .TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .busy          (busy),
    .op_count      (op_count),
    .timeout_count (timeout_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full transaction. done_at = WAIT cycle (1-based, counted from the
  // cycle after the start pulse) in which the ALU reports done; 0 = never.
  // hold = cycles the response is backpressured with a command pending.
  // Entered and left at a negedge with the issuer idle.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op, input logic [3:0] tag,
                        input int done_at, input logic [15:0] res,
                        input int hold);
    logic        to;
    int          n_wait;
    logic [15:0] exp_res;
    to      = !(done_at >= 1 && done_at <= TO);
    n_wait  = to ? TO : done_at;
    exp_res = to ? 16'h0000 : res;

    bus.cmd_valid = 1'b1;
    bus.cmd_a = a; bus.cmd_b = b; bus.cmd_op = op; bus.cmd_tag = tag;
    bus.rsp_ready = 1'b0;
    bus.alu_done  = 1'b0;
    chk("idle_cmd_ready", bus.cmd_ready, 1);
    chk("idle_busy", busy, 0);
    step();

    // ISSUE: stale done pulses and extra commands must be ignored
    bus.cmd_valid  = 1'($urandom);
    bus.cmd_a      = 8'($urandom);
    bus.cmd_b      = 8'($urandom);
    bus.alu_done   = 1'($urandom);
    bus.alu_result = 16'($urandom);
    chk("issue_start", bus.alu_start, 1);
    chk("issue_busy", busy, 1);
    chk("issue_cmd_ready", bus.cmd_ready, 0);
    chk("issue_A", bus.alu_A, a);
    chk("issue_B", bus.alu_B, b);
    chk("issue_op", bus.alu_opcode, op);

    for (int w = 1; w <= n_wait; w++) begin
      step();
      chk("wait_start", bus.alu_start, 0);
      chk("wait_rsp_valid", bus.rsp_valid, 0);
      chk("wait_busy", busy, 1);
      chk("wait_cmd_ready", bus.cmd_ready, 0);
      chk("wait_A", bus.alu_A, a);
      chk("wait_B", bus.alu_B, b);
      chk("wait_op", bus.alu_opcode, op);
      bus.alu_done   = (w == done_at);
      bus.alu_result = (w == done_at) ? res : 16'($urandom);
      bus.cmd_valid  = 1'($urandom);
    end
    if (to && exp_tos != 8'hFF) exp_tos = exp_tos + 8'd1;

    for (int h = 0; h <= hold; h++) begin
      step();
      bus.rsp_ready  = (h == hold);
      bus.cmd_valid  = 1'b1;
      bus.cmd_a      = 8'($urandom);
      bus.cmd_tag    = 4'($urandom);
      bus.alu_done   = 1'($urandom);
      bus.alu_result = 16'($urandom);
      chk("rsp_valid", bus.rsp_valid, 1);
      chk("rsp_result", bus.rsp_result, exp_res);
      chk("rsp_timeout", bus.rsp_timeout, to);
      chk("rsp_op", bus.rsp_op, op);
      chk("rsp_tag", bus.rsp_tag, tag);
      chk("rsp_cmd_ready", bus.cmd_ready, 0);
      chk("rsp_busy", busy, 1);
      chk("rsp_timeout_count", timeout_count, exp_tos);
      chk("rsp_op_count", op_count, exp_ops);
      chk("rsp_A", bus.alu_A, a);
    end

    step();
    exp_ops = exp_ops + 16'd1;
    bus.rsp_ready = 1'b0;
    bus.alu_done  = 1'b0;
    chk("post_rsp_valid", bus.rsp_valid, 0);
    chk("post_op_count", op_count, exp_ops);
    chk("post_timeout_count", timeout_count, exp_tos);
    chk("post_busy", busy, 0);
    chk("post_cmd_ready", bus.cmd_ready, 1);
    chk("post_start", bus.alu_start, 0);
  endtask

  initial begin
    int       d;
    int       r;
    logic [7:0] ra;
    logic [7:0] rb;
    checks = 0;
    errors = 0;
    exp_ops = 16'h0000;
    exp_tos = 8'h00;
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_a = 8'h00; bus.cmd_b = 8'h00;
    bus.cmd_op = 3'b000; bus.cmd_tag = 4'h0;
    bus.rsp_ready = 1'b0; bus.alu_done = 1'b0; bus.alu_result = 16'h0000;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_result", bus.rsp_result, 0);
    chk("rst_rsp_timeout", bus.rsp_timeout, 0);
    chk("rst_alu_start", bus.alu_start, 0);
    chk("rst_alu_A", bus.alu_A, 0);
    chk("rst_busy", busy, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_timeout_count", timeout_count, 0);

    // Add path: done in first WAIT cycle
    run_op(8'h7F, 8'h01, 3'b001, 4'h3, 1, 16'(8'h7F + 8'h01), 0);
    chk("add_op_count", op_count, 16'd1);
    // Multiply: done 9 cycles after start
    ra = 8'hFF; rb = 8'hFF;
    run_op(ra, rb, 3'b010, 4'h5, 9, 16'(ra) * 16'(rb), 0);
    // Timeout: done never arrives
    run_op(8'h12, 8'h34, 3'b011, 4'h9, 0, 16'h0000, 0);
    chk("timeout_count_1", timeout_count, 8'd1);
    // Boundary: done in the last WAIT cycle wins over the timeout
    run_op(8'h56, 8'h78, 3'b100, 4'hA, TO, 16'h1234, 0);
    chk("boundary_timeout_count", timeout_count, 8'd1);
    // Backpressure: 5 cycles of rsp_ready low with a command pending
    run_op(8'hAA, 8'h55, 3'b101, 4'hC, 4, 16'hBEEF, 5);
    // Next command accepted right after the handshake cycle
    run_op(8'h01, 8'h02, 3'b110, 4'hD, 2, 16'h0003, 0);

    // Random commands
    for (int i = 0; i < 20; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      d = 0;
      else if (r == 1) d = $urandom_range(60, 70);
      else             d = $urandom_range(1, 12);
      run_op(8'($urandom), 8'($urandom), 3'($urandom), 4'($urandom),
             d, 16'($urandom), $urandom_range(0, 3));
    end

    // Reset in the third WAIT cycle, then a spurious done while idle
    bus.cmd_valid = 1'b1;
    bus.cmd_a = 8'h11; bus.cmd_b = 8'h22; bus.cmd_op = 3'b001; bus.cmd_tag = 4'h7;
    step();
    bus.cmd_valid = 1'b0;
    chk("mid_issue_start", bus.alu_start, 1);
    repeat (3) step();
    chk("mid_wait_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_ops = 16'h0000;
    exp_tos = 8'h00;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
    chk("mid_rst_op_count", op_count, exp_ops);
    chk("mid_rst_timeout_count", timeout_count, exp_tos);
    chk("mid_rst_start", bus.alu_start, 0);
    chk("mid_rst_cmd_ready", bus.cmd_ready, 1);
    bus.alu_done = 1'b1;
    bus.alu_result = 16'hDEAD;
    step();
    bus.alu_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("spur_rsp_valid", bus.rsp_valid, 0);
      chk("spur_busy", busy, 0);
      chk("spur_op_count", op_count, exp_ops);
      step();
    end

    // Issuer still works after the reset
    run_op(8'h03, 8'h04, 3'b000, 4'h1, 3, 16'h0007, 1);
    chk("final_op_count", op_count, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
